// File: rtl/dm_stage_if.sv
// dm_stage_if -- data-memory request/acknowledge bus between dm_stage and memory.
//   master (stage side): drives mem_req, mem_we, mem_addr, mem_wdata;
//                        samples mem_ack, mem_rdata.
//   slave  (memory side): the mirror image.
// mem_rdata is valid in the cycle mem_ack is high for a load.
interface dm_stage_if #(
  parameter int DW = 17,
  parameter int AW = 16
) ();
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/dm_stage.sv
// dm_stage -- data-memory pipeline stage sitting after the EX ALU.
// Non-memory ops pass ex_alu_res through to WB with one cycle of latency.
// Loads and stores go out on the req/ack bus; the stage stalls upstream
// until the access completes, is rejected, or times out after MAX_WAIT cycles.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ex_*                EX/DM instruction bundle (held stable while stall_DM)
//   stall_DM            freeze upstream
//   mem (master)        data-memory bus (dm_stage_if)
//   wb_*                registered WB bundle, wb_valid is a one-cycle pulse
//   mem_err             sticky error (bad address, re&we, timeout)
//
// Optional feature macro: DM_STORE_FWD_EN -- single-entry buffer of the last
// acked store; a load hitting it completes in one cycle with no request.
module dm_stage #(
  parameter int DW       = 17,
  parameter int AW       = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_alu_res,
  input  logic [DW-1:0] ex_st_data,
  input  logic          ex_re,
  input  logic          ex_we,
  input  logic [3:0]    ex_dst_addr,
  input  logic          ex_rf_we,
  output logic          stall_DM,
  dm_stage_if.master    mem,
  output logic          wb_valid,
  output logic [DW-1:0] wb_data,
  output logic [3:0]    wb_dst_addr,
  output logic          wb_rf_we,
  output logic          mem_err
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t r_state, w_nxt;

  logic [CW-1:0] r_wcnt;
  logic          r_req, r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_dst;
  logic          r_rf_we;
  logic          r_wb_vld, r_wb_rf_we, r_err;
  logic [DW-1:0] r_wb_data;
  logic [3:0]    r_wb_dst;

  logic w_memop, w_oor, w_hit, w_issue, w_ack, w_timeout;

  assign w_memop   = ex_valid & (ex_re | ex_we);
  // MSB of the ALU result flags an address outside the memory window
  assign w_oor     = ex_alu_res[DW-1];
  assign w_ack     = (r_state == S_WAIT) & mem.mem_ack;
  // ack in the last allowed cycle still wins over the timeout
  assign w_timeout = (r_state == S_WAIT) & ~mem.mem_ack & (r_wcnt == CW'(MAX_WAIT - 1));
  assign w_issue   = (r_state == S_IDLE) & w_memop & ~w_oor & ~w_hit;

`ifdef DM_STORE_FWD_EN
  logic          r_fwd_vld;
  logic [AW-1:0] r_fwd_addr;
  logic [DW-1:0] r_fwd_data;
  assign w_hit = ex_re & ~ex_we & ~w_oor & r_fwd_vld & (r_fwd_addr == ex_alu_res[AW-1:0]);
`else
  assign w_hit = 1'b0;
`endif

  // state register + wait counter (counter restarts on each WAIT entry)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE)  r_wcnt <= '0;
      else if (!mem.mem_ack)  r_wcnt <= r_wcnt + CW'(1);
    end
  end

  // next state
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_issue)           w_nxt = S_WAIT;
      S_WAIT: if (w_ack | w_timeout) w_nxt = S_IDLE;
    endcase
  end

  // outputs: the timeout cycle also retires the instruction, so upstream
  // is released then too, otherwise the same op would be replayed in IDLE
  always_comb begin
    stall_DM = 1'b0;
    case (r_state)
      S_IDLE: stall_DM = w_issue;
      S_WAIT: stall_DM = ~mem.mem_ack & ~w_timeout;
    endcase
  end

  // datapath / WB bundle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_dst      <= '0;
      r_rf_we    <= 1'b0;
      r_wb_vld   <= 1'b0;
      r_wb_data  <= '0;
      r_wb_dst   <= '0;
      r_wb_rf_we <= 1'b0;
      r_err      <= 1'b0;
`ifdef DM_STORE_FWD_EN
      r_fwd_vld  <= 1'b0;
      r_fwd_addr <= '0;
      r_fwd_data <= '0;
`endif
    end else begin
      r_wb_vld <= 1'b0;
      if (r_state == S_IDLE) begin
        if (ex_valid && !(ex_re || ex_we)) begin
          r_wb_vld   <= 1'b1;
          r_wb_data  <= ex_alu_res;
          r_wb_dst   <= ex_dst_addr;
          r_wb_rf_we <= ex_rf_we;
        end else if (w_memop && w_oor) begin
          r_wb_vld   <= 1'b1;
          r_wb_data  <= '0;
          r_wb_dst   <= ex_dst_addr;
          r_wb_rf_we <= 1'b0;
          r_err      <= 1'b1;
        end else if (w_memop && w_hit) begin
`ifdef DM_STORE_FWD_EN
          r_wb_vld   <= 1'b1;
          r_wb_data  <= r_fwd_data;
          r_wb_dst   <= ex_dst_addr;
          r_wb_rf_we <= ex_rf_we;
`endif
        end else if (w_memop) begin
          r_req   <= 1'b1;
          r_we    <= ex_we;   // re&we resolves to a store
          r_addr  <= ex_alu_res[AW-1:0];
          r_wdata <= ex_st_data;
          r_dst   <= ex_dst_addr;
          r_rf_we <= ex_rf_we;
          if (ex_re && ex_we) r_err <= 1'b1;
        end
      end else if (w_ack) begin
        r_req      <= 1'b0;
        r_wb_vld   <= 1'b1;
        r_wb_dst   <= r_dst;
        r_wb_data  <= r_we ? '0 : mem.mem_rdata;
        r_wb_rf_we <= r_we ? 1'b0 : r_rf_we;
`ifdef DM_STORE_FWD_EN
        if (r_we) begin
          r_fwd_vld  <= 1'b1;
          r_fwd_addr <= r_addr;
          r_fwd_data <= r_wdata;
        end
`endif
      end else if (w_timeout) begin
        r_req      <= 1'b0;
        r_err      <= 1'b1;
        r_wb_vld   <= 1'b1;
        r_wb_dst   <= r_dst;
        r_wb_data  <= '0;
        r_wb_rf_we <= 1'b0;
`ifdef DM_STORE_FWD_EN
        r_fwd_vld  <= 1'b0;
`endif
      end
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign wb_valid      = r_wb_vld;
  assign wb_data       = r_wb_data;
  assign wb_dst_addr   = r_wb_dst;
  assign wb_rf_we      = r_wb_rf_we;
  assign mem_err       = r_err;
endmodule
